// File: rtl/register_file_pkg.sv
// cpu_defs: definitions shared between the register file and the CPU datapath.
//   REG_ZERO / REG_RA : hard-wired zero register and the link register ($31)
//   regdst_e          : RegDst selector codes for the destination register mux
//   regdst_sel()      : reference destination selection (rt, rd or $31)
package cpu_defs;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    REGDST_RA = 2'b00,
    REGDST_RT = 2'b01,
    REGDST_RD = 2'b10
  } regdst_e;

  // 2'b11 is unused by the control unit; it maps to $0 so a stray code
  // can never clobber a live register.
  function automatic logic [4:0] regdst_sel(regdst_e sel, logic [4:0] rt, logic [4:0] rd);
    logic [4:0] dst;
    case (sel)
      REGDST_RA: dst = REG_RA;
      REGDST_RT: dst = rt;
      REGDST_RD: dst = rd;
      default:   dst = REG_ZERO;
    endcase
    return dst;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// register_file_if: all non-clock/reset signals between the CPU datapath
// (master) and the register file (slave).
//   write side : RegWre, WriteReg, WriteData
//   read side  : ReadReg1/ReadData1, ReadReg2/ReadData2 (operands),
//                DbgReg/DbgData (board display)
//   status     : LastWrReg, LastWrData, WrCount
interface register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              RegWre;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [ADDR_W-1:0] DbgReg;
  logic [DATA_W-1:0] DbgData;
  logic [ADDR_W-1:0] LastWrReg;
  logic [DATA_W-1:0] LastWrData;
  logic [7:0]        WrCount;

  modport master (
    output RegWre, WriteReg, WriteData, ReadReg1, ReadReg2, DbgReg,
    input  ReadData1, ReadData2, DbgData, LastWrReg, LastWrData, WrCount
  );

  modport slave (
    input  RegWre, WriteReg, WriteData, ReadReg1, ReadReg2, DbgReg,
    output ReadData1, ReadData2, DbgData, LastWrReg, LastWrData, WrCount
  );

endinterface

// File: rtl/register_file_read_port.sv
// regfile_read_port: one combinational read port of the register file.
//   rst_n_i   : active-low reset; forces the port to read 0
//   addr_i    : register number to read
//   regs_i    : view of the whole register array (entry 0 tied to 0)
//   wr_en_i / wr_addr_i / wr_data_i : write presented this cycle (bypass)
//   rd_data_o : selected value
module regfile_read_port
  import cpu_defs::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                                rst_n_i,
  input  logic [ADDR_W-1:0]                   addr_i,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]  regs_i,
  input  logic                                wr_en_i,
  input  logic [ADDR_W-1:0]                   wr_addr_i,
  input  logic [DATA_W-1:0]                   wr_data_i,
  output logic [DATA_W-1:0]                   rd_data_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  // Priority: reset, then $0, then the in-flight write, then storage.
  // Checking $0 before the bypass keeps a write aimed at $0 invisible.
  always_comb begin
    rd_data_o = '0;
    if (!rst_n_i || addr_i == ZERO_ADDR) begin
      rd_data_o = '0;
    end else if (wr_en_i && addr_i == wr_addr_i) begin
      rd_data_o = wr_data_i;
    end else begin
      rd_data_o = regs_i[addr_i];
    end
  end

endmodule

// File: rtl/register_file.sv
// register_file: 32 x 32-bit MIPS general-purpose register file.
//   CLK   : system clock, all state updates on the rising edge
//   Reset : asynchronous active-low reset, clears storage and write status
//   bus   : register_file_if.slave carrying the write port, two operand
//           read ports, the debug read port and last-write status
// $0 is not stored. Reads are combinational with write-through bypass so
// a read in the same cycle as a write returns the new value.
module register_file
  import cpu_defs::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic           CLK,
  input  logic           Reset,
  register_file_if.slave bus
);

  localparam int                NREG      = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [NREG-1:1][DATA_W-1:0] regs_q, regs_d;
  logic [ADDR_W-1:0]           last_reg_q, last_reg_d;
  logic [DATA_W-1:0]           last_data_q, last_data_d;
  logic [7:0]                  wr_count_q, wr_count_d;

  logic                        wr_commit;
  logic [NREG-1:0][DATA_W-1:0] regs_view;

  assign wr_commit = bus.RegWre && (bus.WriteReg != ZERO_ADDR);

  always_comb begin
    regs_d      = regs_q;
    last_reg_d  = last_reg_q;
    last_data_d = last_data_q;
    wr_count_d  = wr_count_q;
    if (wr_commit) begin
      regs_d[bus.WriteReg] = bus.WriteData;
      last_reg_d           = bus.WriteReg;
      last_data_d          = bus.WriteData;
      wr_count_d           = wr_count_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      regs_q      <= '0;
      last_reg_q  <= '0;
      last_data_q <= '0;
      wr_count_q  <= '0;
    end else begin
      regs_q      <= regs_d;
      last_reg_q  <= last_reg_d;
      last_data_q <= last_data_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // Read ports index the full address space; slot 0 is a constant zero.
  always_comb begin
    regs_view    = '0;
    regs_view[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      regs_view[i] = regs_q[i];
    end
  end

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .rst_n_i   (Reset),
    .addr_i    (bus.ReadReg1),
    .regs_i    (regs_view),
    .wr_en_i   (bus.RegWre),
    .wr_addr_i (bus.WriteReg),
    .wr_data_i (bus.WriteData),
    .rd_data_o (bus.ReadData1)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .rst_n_i   (Reset),
    .addr_i    (bus.ReadReg2),
    .regs_i    (regs_view),
    .wr_en_i   (bus.RegWre),
    .wr_addr_i (bus.WriteReg),
    .wr_data_i (bus.WriteData),
    .rd_data_o (bus.ReadData2)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dbg (
    .rst_n_i   (Reset),
    .addr_i    (bus.DbgReg),
    .regs_i    (regs_view),
    .wr_en_i   (bus.RegWre),
    .wr_addr_i (bus.WriteReg),
    .wr_data_i (bus.WriteData),
    .rd_data_o (bus.DbgData)
  );

  assign bus.LastWrReg  = last_reg_q;
  assign bus.LastWrData = last_data_q;
  assign bus.WrCount    = wr_count_q;

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic CLK;
  logic Reset;

  register_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  register_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: plain array of architectural register contents.
  logic [31:0] m_regs [32];
  logic [4:0]  m_last_reg;
  logic [31:0] m_last_data;
  int          m_count;

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_last_reg  = 5'd0;
    m_last_data = 32'h0;
    m_count     = 0;
  endfunction

  initial model_clear();

  always @(negedge Reset) model_clear();

  always @(posedge CLK) begin
    if (!Reset) begin
      model_clear();
    end else if (bus.RegWre && bus.WriteReg != 5'd0) begin
      m_regs[bus.WriteReg] = bus.WriteData;
      m_last_reg           = bus.WriteReg;
      m_last_data          = bus.WriteData;
      m_count              = (m_count + 1) % 256;
    end
  end

  function automatic logic [31:0] exp_rd(logic [4:0] a);
    if (!Reset || a == 5'd0) return 32'h0;
    if (bus.RegWre && a == bus.WriteReg) return bus.WriteData;
    return m_regs[a];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, 3 time units after inputs are driven.
  always begin
    @(negedge CLK);
    #3;
    if (chk_en) begin
      chk("ReadData1",  bus.ReadData1,          exp_rd(bus.ReadReg1));
      chk("ReadData2",  bus.ReadData2,          exp_rd(bus.ReadReg2));
      chk("DbgData",    bus.DbgData,            exp_rd(bus.DbgReg));
      chk("LastWrReg",  {27'h0, bus.LastWrReg}, {27'h0, m_last_reg});
      chk("LastWrData", bus.LastWrData,         m_last_data);
      chk("WrCount",    {24'h0, bus.WrCount},   32'(m_count));
    end
  end

  // Drive one cycle of inputs at the falling edge, then let them settle.
  task automatic drive(bit we, logic [4:0] wa, logic [31:0] wd,
                       logic [4:0] a1, logic [4:0] a2, logic [4:0] ad);
    @(negedge CLK);
    bus.RegWre    = we;
    bus.WriteReg  = wa;
    bus.WriteData = wd;
    bus.ReadReg1  = a1;
    bus.ReadReg2  = a2;
    bus.DbgReg    = ad;
    #3;
  endtask

  initial begin
    Reset         = 1'b0;
    bus.RegWre    = 1'b1;
    bus.WriteReg  = 5'd5;
    bus.WriteData = 32'hDEADBEEF;
    bus.ReadReg1  = 5'd5;
    bus.ReadReg2  = 5'd5;
    bus.DbgReg    = 5'd5;
    chk_en        = 1'b1;

    // Reset held during an attempted write.
    repeat (3) drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
    chk("rst_rd1_bypass_off", bus.ReadData1, 32'h0);
    chk("rst_wrcount",        {24'h0, bus.WrCount}, 32'h0);
    @(negedge CLK);
    Reset      = 1'b1;
    bus.RegWre = 1'b0;
    #3;
    chk("rst_reg5_after_release", bus.ReadData1, 32'h0);

    // Basic write/read.
    drive(1'b1, 5'd8, 32'h00000010, 5'd0, 5'd0, 5'd0);
    drive(1'b1, 5'd9, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'h0,        5'd8, 5'd9, 5'd8);
    chk("basic_rd1",       bus.ReadData1, 32'h00000010);
    chk("basic_rd2",       bus.ReadData2, 32'hFFFFFFFF);
    chk("basic_lastwrreg", {27'h0, bus.LastWrReg}, 32'd9);
    chk("basic_wrcount",   {24'h0, bus.WrCount}, 32'd2);

    // Zero register.
    drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0);
    chk("zero_rd1", bus.ReadData1, 32'h0);
    chk("zero_rd2", bus.ReadData2, 32'h0);
    chk("zero_dbg", bus.DbgData,   32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    chk("zero_wrcount",    {24'h0, bus.WrCount}, 32'd2);
    chk("zero_lastwrreg",  {27'h0, bus.LastWrReg}, 32'd9);
    chk("zero_lastwrdata", bus.LastWrData, 32'hFFFFFFFF);

    // Bypass.
    drive(1'b1, 5'd3, 32'h1, 5'd0, 5'd0, 5'd0);
    drive(1'b1, 5'd3, 32'h2, 5'd3, 5'd3, 5'd3);
    chk("bypass_rd1", bus.ReadData1, 32'h2);
    chk("bypass_rd2", bus.ReadData2, 32'h2);
    chk("bypass_dbg", bus.DbgData,   32'h2);
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
    chk("bypass_after_edge", bus.ReadData1, 32'h2);

    // Link register write.
    drive(1'b1, 5'd31, 32'h00400008, 5'd0, 5'd0, 5'd0);
    drive(1'b0, 5'd0,  32'h0,        5'd31, 5'd0, 5'd31);
    chk("link_rd1",       bus.ReadData1, 32'h00400008);
    chk("link_lastwrreg", {27'h0, bus.LastWrReg}, 32'd31);

    // Counter wrap from a clean reset: 256 writes to $1.
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 5'd1, 32'hA000_0000 + 32'(i), 5'd1, 5'd0, 5'd0);
    end
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd1, 5'd0);
    chk("wrap_wrcount", {24'h0, bus.WrCount}, 32'h0);
    chk("wrap_reg1",    bus.ReadData1, 32'hA000_00FF);

    // Randomized traffic, addresses biased toward collisions.
    for (int n = 0; n < 2000; n++) begin
      logic [4:0]  wa, a1, a2, ad;
      logic [31:0] wd;
      bit          we;
      we = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom();
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ad = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 150) == 0) begin
        // Reset pulse in the middle of a cycle carrying a write.
        @(negedge CLK);
        bus.RegWre    = 1'b1;
        bus.WriteReg  = wa;
        bus.WriteData = wd;
        bus.ReadReg1  = a1;
        bus.ReadReg2  = a2;
        bus.DbgReg    = ad;
        #1 Reset = 1'b0;
        @(negedge CLK);
        #1 Reset = 1'b1;
      end else begin
        drive(we, wa, wd, a1, a2, ad);
      end
    end

    @(negedge CLK);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

- MIPS-style 32 x 32-bit general-purpose register file for the lab single-cycle and multi-cycle CPU datapath.
- Consumes the 5-bit destination register number from the RegDst destination selector (rt, rd or $31) together with write-back data and the RegWre strobe.
- Supplies two combinational operand read ports to the ALU stage and one debug read port for the board display.
- Tracks the most recent committed write so the display can show write-back activity.

## Interface

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register number width (32 registers)

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-low reset
- RegWre  in  1  write enable from control unit
- WriteReg  in  ADDR_W  destination register number from the RegDst selector
- WriteData  in  DATA_W  write-back value (ALU result, memory data or PC+4)
- ReadReg1  in  ADDR_W  rs register number
- ReadReg2  in  ADDR_W  rt register number
- ReadData1  out  DATA_W  rs operand
- ReadData2  out  DATA_W  rt operand
- DbgReg  in  ADDR_W  register number selected by board switches
- DbgData  out  DATA_W  value of DbgReg, using the same bypass rules as the operand ports
- LastWrReg  out  ADDR_W  register number of the last committed write
- LastWrData  out  DATA_W  data of the last committed write
- WrCount  out  8  committed-write counter, wraps 255 -> 0

## Operation

- Storage: 31 registers, $1 to $31. $0 is not stored and always reads 0.
- Write commit: on a rising CLK edge, write when Reset=1, RegWre=1 and WriteReg != 0:
  - regs[WriteReg] <= WriteData
  - LastWrReg <= WriteReg
  - LastWrData <= WriteData
  - WrCount <= WrCount + 1, modulo 256
- Writes to $0: no storage update, LastWr* unchanged, WrCount unchanged.
- Reads (ReadData1, ReadData2, DbgData) are combinational on the address. Each port returns:
  - 0 if the address is 0.
  - WriteData if RegWre=1, the address equals WriteReg and WriteReg != 0 (write-through bypass, so a read in the same cycle as the write returns the new value).
  - Otherwise the stored register value.
- All three ports may address the same register as each other and as WriteReg at once; all return the same value.
- Reset (asynchronous, Reset=0):
  - All registers cleared to 0.
  - LastWrReg = 0, LastWrData = 0, WrCount = 0.
  - Bypass is suppressed, so ReadData1, ReadData2 and DbgData read 0 while Reset=0 regardless of RegWre or WriteData.
- Reset asserted mid-cycle, with a write pending: the write is lost; no partial update.
- Reset deassertion: takes effect at the next rising CLK edge. A write presented at that edge commits normally.
- X or unknown WriteReg is not expected; no protection is required.

## Timing

- Write latency: 1 cycle. The value is stored at the rising edge where RegWre=1 and is visible from stored state from the next cycle onward.
- Read latency: 0 cycles, purely combinational, including the bypass path.
- Bypass path: WriteData -> ReadData* is a combinational path. The control unit must hold RegWre, WriteReg and WriteData stable across the edge.
- LastWrReg, LastWrData and WrCount are registered and update at the same edge as the storage write.
- No handshake: a write is accepted unconditionally every cycle RegWre=1.

## Structure

- Shared package/header `cpu_defs`:
  - REG_ZERO = 5'd0
  - REG_RA = 5'd31
  - RegDst codes: 2'b00 = $31, 2'b01 = rt, 2'b10 = rd
  - DATA_W and ADDR_W defaults
- Sub-module `regfile_read_port`:
  - Inputs: address, storage array view, write bypass inputs, Reset.
  - Output: read data.
  - Implements zero, bypass and storage selection.
  - Instantiated three times (ReadData1, ReadData2, DbgData).

## Test plan

- Reset during activity: hold Reset=0 with RegWre=1, WriteReg=5, WriteData=0xDEADBEEF.
  - Required: ReadData1 for ReadReg1=5 reads 0, WrCount=0, and $5 still reads 0 after release.
- Basic write/read: write $8=0x00000010 and $9=0xFFFFFFFF on consecutive cycles, then ReadReg1=8, ReadReg2=9.
  - Required: 0x00000010 and 0xFFFFFFFF, LastWrReg=9, WrCount=2.
- Zero register: RegWre=1, WriteReg=0, WriteData=0x12345678, read $0 on all ports.
  - Required: 0 on every port, WrCount unchanged, LastWr* unchanged.
- Bypass: $3 holds 0x1, present RegWre=1, WriteReg=3, WriteData=0x2 with ReadReg1=ReadReg2=DbgReg=3.
  - Required: all three ports read 0x2 in the same cycle, and read 0x2 after the edge.
- Link write: WriteReg=31 (REG_RA), WriteData=0x00400008.
  - Required: $31 reads 0x00400008, LastWrReg=31.
- Counter wrap: 256 writes to $1.
  - Required: WrCount returns to 0 and $1 holds the last data written.
